cordic_phase_gen: RTL
=====================

Name: cordic_phase_gen

Overview:
Upstream driver for the CORDIC sine/cosine core. A 32-bit phase accumulator (NCO) steps by a programmable tuning word. Each phase is folded into the CORDIC convergence range (−90°..+90°) by a ±90° quadrant pre-rotation applied to the start vector. The block presents angle/Xin/Yin to the core every enabled cycle and generates a valid strobe delayed to line up with the core's COSout/SINout. It also keeps a running count of valid output samples.

Parameters:
WIDTH, 16, width of x_out/y_out (CORDIC Xin/Yin)
PHASE_W, 32, phase/angle width; full scale 2^32 = 360°
LATENCY, 16, CORDIC cycles from angle/Xin/Yin sampled to COSout/SINout valid
AMP, 19429, start-vector magnitude (32000/1.647, gain-compensated)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
en  in  1  emit one sample and advance accumulator this cycle
load_phase  in  1  synchronous accumulator clear (phase restart)
ftw  in  32  frequency tuning word, unsigned phase increment per sample
phase_offset  in  32  added to accumulator before folding
angle_out  out  32  to CORDIC angle, folded, always in [−2^30, 2^30)
x_out  out  16  to CORDIC Xin, two's complement
y_out  out  16  to CORDIC Yin, two's complement
cordic_valid  out  1  angle_out/x_out/y_out hold a new sample
out_valid  out  1  CORDIC COSout/SINout correspond to an issued sample
sample_cnt  out  16  number of out_valid cycles since reset, wraps

Behaviour:
- Reset (rst=1 at edge): acc=0, angle_out=0, x_out=0, y_out=0, cordic_valid=0, valid delay line all 0, out_valid=0, sample_cnt=0. rst overrides en/load_phase. Reset mid-run flushes in-flight valids, so no out_valid for pre-reset samples.
- Edge with en=1: p = acc_eff + phase_offset (mod 2^32). acc_eff = 0 if load_phase=1, else acc. acc <= acc_eff + ftw. Outputs register the fold of p. cordic_valid <= 1.
- Edge with en=0: outputs hold, cordic_valid <= 0. acc <= 0 if load_phase=1, else holds.
- Fold on q = p[31:30]:
  - q=00 or 11: angle=p, x=+AMP, y=0
  - q=01: angle=p−2^30, x=0, y=+AMP
  - q=10: angle=p+2^30, x=0, y=−AMP
- Exactly 90° (0x40000000) maps to angle 0, x=0, y=+AMP. 180° (0x80000000) maps to angle 0xC0000000, x=0, y=−AMP.
- Arithmetic is all modulo 2^32 with no saturation. Accumulator wrap is silent and phase-continuous.
- Latency: input edge → angle_out/cordic_valid is 1 cycle. out_valid = cordic_valid delayed exactly LATENCY cycles via a shift register, so it is asserted on the cycle the core's output matches that sample. Gaps in en propagate as gaps in out_valid.
- sample_cnt increments on each cycle out_valid=1, wrapping 0xFFFF→0x0000.
- A ftw or phase_offset change applies to the first sample issued after the edge at which it is sampled. There is no partial-cycle effect.
- No backpressure: the CORDIC pipeline is free-running and the consumer must accept every out_valid sample.

Test Plan:
- Reset, then en=1, ftw=0x10000000, offset=0, load_phase pulsed with the first en → samples 0..15 have p=k·0x10000000. Sample 5 (p=0x50000000): angle=0x10000000, x=0, y=0x4BE5. Sample 8: angle=0xC0000000, x=0, y=0xB41B. Sample 12: angle=0xC0000000, x=0x4BE5, y=0. Sample 16 wraps to p=0.
- Single en pulse after reset → cordic_valid high for exactly 1 cycle, 1 cycle later. out_valid high exactly LATENCY cycles after cordic_valid, otherwise 0. sample_cnt=1.
- en pattern 1,1,0,1 → out_valid pattern 1,1,0,1 shifted by LATENCY. acc advanced 3·ftw.
- load_phase with en=1 mid-run, offset=0x40000000 → that sample's p=0x40000000 (angle 0, x=0, y=0x4BE5). Next sample's p=ftw+0x40000000.
- rst asserted while 10 samples are in flight → no out_valid afterwards. All outputs equal reset values the next cycle. sample_cnt=0.
- Feed 65537 valid samples → sample_cnt wraps to 0x0001. With CORDIC attached, angles 45°/60°/75°/90° give COSout/SINout within ±2 LSB of 32000·cos/sin.

Source files
------------

// File: rtl/cordic_phase_gen.sv
// Phase accumulator and quadrant folding that feeds the CORDIC sine/cosine core,
// with a valid strobe delayed to line up with the core output.
module cordic_phase_gen #(
  parameter int WIDTH   = 16,
  parameter int PHASE_W = 32,
  parameter int LATENCY = 16,
  parameter int AMP     = 19429
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load_phase,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] phase_offset,
  output logic [PHASE_W-1:0] angle_out,
  output logic [WIDTH-1:0]   x_out,
  output logic [WIDTH-1:0]   y_out,
  output logic               cordic_valid,
  output logic               out_valid,
  output logic [15:0]        sample_cnt
);

  localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(1) << (PHASE_W - 2);
  localparam logic [WIDTH-1:0]   AMP_POS = WIDTH'(AMP);
  localparam logic [WIDTH-1:0]   AMP_NEG = WIDTH'(0) - WIDTH'(AMP);

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] acc_eff;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] fold_angle;
  logic [WIDTH-1:0]   fold_x;
  logic [WIDTH-1:0]   fold_y;
  logic [LATENCY-1:0] vld_sr;

  assign acc_eff = load_phase ? '0 : acc;
  assign phase   = acc_eff + phase_offset;

  // Quadrants 1 and 2 are rotated by -/+90 deg and the start vector absorbs
  // the rotation, so the core only ever sees angles in [-90, +90).
  always_comb begin
    fold_angle = phase;
    fold_x     = AMP_POS;
    fold_y     = '0;
    case (phase[PHASE_W-1:PHASE_W-2])
      2'b01: begin
        fold_angle = phase - QUARTER;
        fold_x     = '0;
        fold_y     = AMP_POS;
      end
      2'b10: begin
        fold_angle = phase + QUARTER;
        fold_x     = '0;
        fold_y     = AMP_NEG;
      end
      default: begin
        fold_angle = phase;
        fold_x     = AMP_POS;
        fold_y     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      angle_out    <= '0;
      x_out        <= '0;
      y_out        <= '0;
      cordic_valid <= 1'b0;
      vld_sr       <= '0;
      sample_cnt   <= '0;
    end else begin
      if (en) begin
        acc          <= acc_eff + ftw;
        angle_out    <= fold_angle;
        x_out        <= fold_x;
        y_out        <= fold_y;
        cordic_valid <= 1'b1;
      end else begin
        acc          <= acc_eff;
        cordic_valid <= 1'b0;
      end
      vld_sr[0] <= cordic_valid;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      if (out_valid) begin
        sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

  assign out_valid = vld_sr[LATENCY-1];

endmodule
